button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100_000_000, gives the input clock frequency in Hz.
REQ-002 Parameter DEBOUNCE_MS, default 10, gives the stability window in ms; DB_CNT = CLK_FREQ_HZ/1000*DEBOUNCE_MS cycles.
REQ-003 Parameter LONG_PRESS_MS, default 1000, gives the hold time in ms; LP_CNT = CLK_FREQ_HZ/1000*LONG_PRESS_MS cycles.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 means the raw pin reads 0 when pressed.
REQ-005 clk  input  1  the single system clock; all logic is on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 btn_in  input  1  raw, asynchronous, bouncing pushbutton pin.
REQ-008 btn_level  output  1  debounced level; 1 means pressed.
REQ-009 press_pulse  output  1  one-cycle strobe on an accepted press.
REQ-010 release_pulse  output  1  one-cycle strobe on an accepted release.
REQ-011 long_press_pulse  output  1  one-cycle strobe when a press has been held for LP_CNT cycles.
REQ-012 press_count  output  8  count of accepted presses; wraps from 255 to 0.

Function
REQ-013 btn_in SHALL pass through a 2-flop synchronizer and then be normalized by ACTIVE_LOW, giving the signal s (1 means pressed).
REQ-014 The FSM SHALL have exactly four states: IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-015 IDLE: when s=1, go to PRESS_WAIT and clear the debounce counter; otherwise stay.
REQ-016 PRESS_WAIT, bounce case: when s=0, return to IDLE, clear the counter, and emit no pulse.
REQ-017 PRESS_WAIT, accept case: when s=1 and counter=DB_CNT-1, go to HELD.
REQ-018 On entry to HELD: assert press_pulse for one cycle, set btn_level, increment press_count, and clear the long counter and the long_done flag.
REQ-019 HELD: the long counter SHALL increment each cycle and saturate at LP_CNT-1.
REQ-020 HELD: when the long counter first reaches LP_CNT-1 and long_done=0, assert long_press_pulse for one cycle and set long_done; at most one long pulse per press.
REQ-021 HELD: when s=0, go to RELEASE_WAIT and clear the debounce counter.
REQ-022 RELEASE_WAIT, bounce case: when s=1, return to HELD; the long counter and long_done SHALL be preserved.
REQ-023 RELEASE_WAIT: the long counter SHALL keep counting; long_press_pulse SHALL NOT fire in this state.
REQ-024 RELEASE_WAIT, accept case: when s=0 and counter=DB_CNT-1, go to IDLE, assert release_pulse for one cycle, and clear btn_level.
REQ-025 All outputs SHALL be registered.
REQ-026 Latency: a clean raw edge produces its pulse exactly DB_CNT+3 clk edges after the first edge that samples the new level.
REQ-027 Counter widths SHALL be $clog2(DB_CNT+1) and $clog2(LP_CNT+1).
REQ-028 Counter arithmetic SHALL be unsigned with no wrap; press_count alone wraps modulo 256.
REQ-029 press_pulse and release_pulse SHALL never assert in the same cycle.
REQ-030 long_press_pulse SHALL never coincide with release_pulse.

Reset
REQ-031 While rst=1, all logic SHALL be cleared asynchronously: state=IDLE; all counters, long_done and press_count=0; both synchronizer flops at the released level; every output 0.
REQ-032 Reset asserted mid-press SHALL drop btn_level immediately and emit no release_pulse.
REQ-033 After reset deassertion with the button held, a press SHALL be accepted after DB_CNT+3 cycles.

Structure
REQ-034 A shared package SHALL hold the state enum typedef and a ms_to_cycles(freq, ms) constant function.
REQ-035 The synchronizer SHALL be a sub-module named sync_2ff, with a reset-value parameter; the FSM and counters SHALL live in button_debouncer.

Verification (CLK_FREQ_HZ=1_000_000, DEBOUNCE_MS=1 so DB_CNT=1000, LONG_PRESS_MS=5 so LP_CNT=5000, ACTIVE_LOW=1)
REQ-036 Clean press: btn_in 1->0 held for 2000 cycles -> press_pulse at cycle 1003, btn_level=1, press_count=1.
REQ-037 Bounce: btn_in toggles every 300 cycles for 3000 cycles, then stays 1 -> no pulses, btn_level stays 0.
REQ-038 Long press: hold for 7000 cycles -> exactly one long_press_pulse, 5000 cycles after press_pulse; release_pulse follows the release by 1003 cycles.
REQ-039 Release bounce: while HELD, a 400-cycle high glitch -> stays HELD, no release_pulse, no second press_pulse.
REQ-040 Wrap and reset: 256 clean presses -> press_count=0; rst pulsed while HELD -> all outputs 0 within the same cycle, no release_pulse.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared types and helpers for the pushbutton debouncer.
// Holds the FSM state encoding and the ms-to-cycles conversion.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_e;

  function automatic int ms_to_cycles(input int freq, input int ms);
    return freq / 1000 * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both flops reset to RST_VAL so reset does not fake an input edge.
module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic q1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounced pushbutton with press/release/long-press strobes
// and a wrapping press counter; all outputs are registered.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int DEBOUNCE_MS   = 10,
  parameter int LONG_PRESS_MS = 1000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press_pulse,
  output logic [7:0] press_count
);

  localparam int DB_CNT = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int LP_CNT = ms_to_cycles(CLK_FREQ_HZ, LONG_PRESS_MS);
  localparam int DB_W   = $clog2(DB_CNT + 1);
  localparam int LP_W   = $clog2(LP_CNT + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_CNT - 1);

  logic sync_q;
  logic s_q;

  sync_2ff #(
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync_q)
  );

  // Polarity-normalized level, 1 = pressed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= 1'b0;
    else     s_q <= sync_q ^ ACTIVE_LOW;
  end

  db_state_e       state_q, state_d;
  logic [DB_W-1:0] db_q, db_d;
  logic [LP_W-1:0] lp_q, lp_d;
  logic            ld_q, ld_d;
  logic            level_d;
  logic            press_d;
  logic            rel_d;
  logic            long_d;
  logic [7:0]      count_d;

  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    lp_d    = lp_q;
    ld_d    = ld_q;
    level_d = btn_level;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    count_d = press_count;
    unique case (state_q)
      IDLE: begin
        if (s_q) begin
          state_d = PRESS_WAIT;
          db_d    = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s_q) begin
          state_d = IDLE;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
          level_d = 1'b1;
          count_d = press_count + 8'd1;
          lp_d    = '0;
          ld_d    = 1'b0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      HELD: begin
        if (lp_q != LP_LAST) lp_d = lp_q + 1'b1;
        if (lp_q == LP_LAST && !ld_q) begin
          long_d = 1'b1;
          ld_d   = 1'b1;
        end
        if (!s_q) begin
          state_d = RELEASE_WAIT;
          db_d    = '0;
        end
      end
      RELEASE_WAIT: begin
        // Long timer keeps running so a release bounce resumes it
        if (lp_q != LP_LAST) lp_d = lp_q + 1'b1;
        if (s_q) begin
          state_d = HELD;
        end else if (db_q == DB_LAST) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          level_d = 1'b0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      db_q             <= '0;
      lp_q             <= '0;
      ld_q             <= 1'b0;
      btn_level        <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      press_count      <= '0;
    end else begin
      state_q          <= state_d;
      db_q             <= db_d;
      lp_q             <= lp_d;
      ld_q             <= ld_d;
      btn_level        <= level_d;
      press_pulse      <= press_d;
      release_pulse    <= rel_d;
      long_press_pulse <= long_d;
      press_count      <= count_d;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed scoreboard bench for button_debouncer.
// A slow instance covers timing; a fast one covers count wrap.
module tb_button_debouncer;

  localparam int DB  = 1000;
  localparam int LP  = 5000;
  localparam int LAT = DB + 3;
  localparam int FLAT = 4 + 3;

  localparam int K_PRESS  = 0;
  localparam int K_REL    = 1;
  localparam int K_LONG   = 2;
  localparam int K_FPRESS = 3;
  localparam int K_FREL   = 4;
  localparam int K_FLONG  = 5;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b1;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press_pulse;
  logic [7:0] press_count;

  logic       fbtn_in = 1'b1;
  logic       f_level;
  logic       f_press;
  logic       f_rel;
  logic       f_long;
  logic [7:0] f_count;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  button_debouncer #(
    .CLK_FREQ_HZ   (1_000_000),
    .DEBOUNCE_MS   (1),
    .LONG_PRESS_MS (5),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .btn_in           (btn_in),
    .btn_level        (btn_level),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_press_pulse (long_press_pulse),
    .press_count      (press_count)
  );

  button_debouncer #(
    .CLK_FREQ_HZ   (4_000),
    .DEBOUNCE_MS   (1),
    .LONG_PRESS_MS (5),
    .ACTIVE_LOW    (1'b1)
  ) dut_fast (
    .clk              (clk),
    .rst              (rst),
    .btn_in           (fbtn_in),
    .btn_level        (f_level),
    .press_pulse      (f_press),
    .release_pulse    (f_rel),
    .long_press_pulse (f_long),
    .press_count      (f_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (press_pulse)      obs_q.push_back('{K_PRESS, cyc});
      if (release_pulse)    obs_q.push_back('{K_REL, cyc});
      if (long_press_pulse) obs_q.push_back('{K_LONG, cyc});
      if (f_press)          obs_q.push_back('{K_FPRESS, cyc});
      if (f_rel)            obs_q.push_back('{K_FREL, cyc});
      if (f_long)           obs_q.push_back('{K_FLONG, cyc});
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int at);
    exp_q.push_back('{kind, at});
  endtask

  task automatic check_events(input string tag);
    ev_t e;
    ev_t o;
    chk({tag, " event count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, " event kind"}, o.kind, e.kind);
      chk({tag, " event cycle"}, o.cyc, e.cyc);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic drive(input logic v, output int t);
    @(posedge clk);
    #1;
    btn_in = v;
    t = cyc;
  endtask

  task automatic fdrive(input logic v, output int t);
    @(posedge clk);
    #1;
    fbtn_in = v;
    t = cyc;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int t, t2, p;

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst level", btn_level, 0);
    chk("rst press", press_pulse, 0);
    chk("rst release", release_pulse, 0);
    chk("rst long", long_press_pulse, 0);
    chk("rst count", press_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cyc(5);

    // Clean press then release
    drive(1'b0, t);
    expect_ev(K_PRESS, t + 1 + LAT);
    wait_cyc(1999);
    @(negedge clk);
    chk("clean level", btn_level, 1);
    chk("clean count", press_count, 1);
    drive(1'b1, t);
    expect_ev(K_REL, t + 1 + LAT);
    wait_cyc(1500);
    @(negedge clk);
    chk("clean rel level", btn_level, 0);
    check_events("clean");

    // Bounce shorter than the window
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 1'b0 : 1'b1, t);
      wait_cyc(299);
    end
    wait_cyc(1500);
    @(negedge clk);
    chk("bounce level", btn_level, 0);
    chk("bounce count", press_count, 1);
    check_events("bounce");

    // Long press
    drive(1'b0, t);
    p = t + 1 + LAT;
    expect_ev(K_PRESS, p);
    expect_ev(K_LONG, p + LP);
    wait_cyc(6999);
    drive(1'b1, t2);
    expect_ev(K_REL, t2 + 1 + LAT);
    wait_cyc(1500);
    @(negedge clk);
    chk("long count", press_count, 2);
    check_events("long");

    // Release glitch while held
    drive(1'b0, t);
    expect_ev(K_PRESS, t + 1 + LAT);
    wait_cyc(1999);
    drive(1'b1, t);
    wait_cyc(399);
    drive(1'b0, t);
    wait_cyc(1999);
    @(negedge clk);
    chk("glitch level", btn_level, 1);
    chk("glitch count", press_count, 3);
    drive(1'b1, t);
    expect_ev(K_REL, t + 1 + LAT);
    wait_cyc(1500);
    check_events("glitch");

    // Wrap on the fast instance
    for (int i = 0; i < 256; i++) begin
      fdrive(1'b0, t);
      expect_ev(K_FPRESS, t + 1 + FLAT);
      wait_cyc(11);
      fdrive(1'b1, t);
      expect_ev(K_FREL, t + 1 + FLAT);
      wait_cyc(11);
      if (i == 254) begin
        @(negedge clk);
        chk("wrap count 255", f_count, 255);
      end
    end
    @(negedge clk);
    chk("wrap count 0", f_count, 0);
    chk("wrap level", f_level, 0);
    check_events("wrap");

    // Reset while held, then button still held
    drive(1'b0, t);
    expect_ev(K_PRESS, t + 1 + LAT);
    wait_cyc(1499);
    @(negedge clk);
    chk("pre-rst level", btn_level, 1);
    chk("pre-rst count", press_count, 4);
    rst = 1'b1;
    #1;
    chk("mid-rst level", btn_level, 0);
    chk("mid-rst count", press_count, 0);
    chk("mid-rst release", release_pulse, 0);
    chk("mid-rst press", press_pulse, 0);
    wait_cyc(3);
    #1;
    rst = 1'b0;
    t = cyc;
    expect_ev(K_PRESS, t + 1 + LAT);
    wait_cyc(LAT + 10);
    @(negedge clk);
    chk("post-rst level", btn_level, 1);
    chk("post-rst count", press_count, 1);
    drive(1'b1, t);
    expect_ev(K_REL, t + 1 + LAT);
    wait_cyc(1500);
    check_events("reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
